parameterized_counter: RTL and testbench



---
 rtl/parameterized_counter.sv | 46 ++++
 tb/tb_parameterized_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/parameterized_counter.sv
// N-bit free-running up-counter with synchronous load, async active-high reset
// and terminal-count flag; PARAMETERIZED_COUNTER_WRAP_FLAG_EN adds a rollover pulse.
module parameterized_counter #(
  parameter int          N           = 8,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] count_out,
  output logic         tc
`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
  ,
  output logic         wrap
`endif
);

  localparam logic [N-1:0] RST_VAL  = N'(RESET_VALUE);
  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] ALL_ONES = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_out <= RST_VAL;
    end else if (load_en) begin
      count_out <= data_in;
    end else begin
      count_out <= count_out + ONE;
    end
  end

  assign tc = (count_out == ALL_ONES);

`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
  // Only a genuine increment out of all-ones counts as a rollover; loads never do.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc && !load_en;
    end
  end
`endif

endmodule

// File: tb/tb_parameterized_counter.sv
// Self-checking bench: 8-bit default counter plus a 4-bit counter whose reset
// value (0x1F) truncates to all-ones, both checked against an arithmetic model.
module tb_parameterized_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] data_in4;
  logic [7:0] count8;
  logic [3:0] count4;
  logic       tc8, tc4;
`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
  logic       wrap8, wrap4;
`endif

  assign data_in4 = data_in[3:0];

  always #5 clk = ~clk;

  parameterized_counter #(.N(8), .RESET_VALUE(0)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .data_in  (data_in),
    .count_out(count8),
    .tc       (tc8)
`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
    ,
    .wrap     (wrap8)
`endif
  );

  parameterized_counter #(.N(4), .RESET_VALUE(32'h1F)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .data_in  (data_in4),
    .count_out(count4),
    .tc       (tc4)
`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
    ,
    .wrap     (wrap4)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain modular arithmetic on integers.
  int exp8 = 0;
  int exp4 = 0;
  int exp_wrap8 = 0;
  int exp_wrap4 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cnt8"}, 32'(count8), 32'(exp8));
    check({tag, ".tc8"},  32'(tc8),    (exp8 == 255) ? 32'd1 : 32'd0);
    check({tag, ".cnt4"}, 32'(count4), 32'(exp4));
    check({tag, ".tc4"},  32'(tc4),    (exp4 == 15) ? 32'd1 : 32'd0);
`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
    check({tag, ".wrap8"}, 32'(wrap8), 32'(exp_wrap8));
    check({tag, ".wrap4"}, 32'(wrap4), 32'(exp_wrap4));
`endif
  endtask

  task automatic model_reset();
    exp8 = 0;
    exp4 = 32'h1F % 16;
    exp_wrap8 = 0;
    exp_wrap4 = 0;
  endtask

  // One clock edge with the given controls; inputs change 1 time unit after an edge.
  task automatic step(input logic ld, input logic [7:0] d, input string tag);
    load_en = ld;
    data_in = d;
    @(posedge clk);
    if (ld) begin
      exp_wrap8 = 0;
      exp_wrap4 = 0;
      exp8 = int'(d) % 256;
      exp4 = int'(d) % 16;
    end else begin
      exp_wrap8 = (exp8 == 255) ? 1 : 0;
      exp_wrap4 = (exp4 == 15) ? 1 : 0;
      exp8 = (exp8 + 1) % 256;
      exp4 = (exp4 + 1) % 16;
    end
    #1;
    check_all(tag);
  endtask

  task automatic hold_reset_edge(input string tag);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset behaviour
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("rst_async");
    hold_reset_edge("rst_hold0");
    hold_reset_edge("rst_hold1");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, "post_rst");
    check("post_rst_six", 32'(count8), 32'h06);

    // Load of zero from a running count
    step(1'b1, 8'h00, "load_zero");
    for (int i = 0; i < 4; i++) step(1'b0, 8'hA5, "after_load_zero");
    check("load_zero_four", 32'(count8), 32'h04);

    // Load mid-range
    step(1'b1, 8'h38, "load_38");
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, "after_load_38");
    check("load_38_five", 32'(count8), 32'h3D);

    // Wrap from all-ones
    step(1'b1, 8'hFF, "load_ff");
    check("load_ff_tc", 32'(tc8), 32'd1);
    step(1'b0, 8'h00, "wrap_edge");
    check("wrap_edge_cnt", 32'(count8), 32'h00);
    step(1'b0, 8'h00, "after_wrap1");
    step(1'b0, 8'h00, "after_wrap2");
    check("after_wrap_two", 32'(count8), 32'h02);

    // Reset asserted between edges while counting
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, "pre_midrst");
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("midrst_async");
    hold_reset_edge("midrst_hold0");
    hold_reset_edge("midrst_hold1");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, "post_midrst");
    check("post_midrst_four", 32'(count8), 32'h04);

    // Load has priority over rollover at terminal count
    step(1'b1, 8'hFF, "prio_load_ff");
    step(1'b1, 8'h10, "prio_load_10");
    check("prio_cnt", 32'(count8), 32'h10);

    // Randomized load/increment mix, biased towards all-ones loads to exercise rollover
    for (int i = 0; i < 400; i++) begin
      logic       ld;
      logic [7:0] d;
      ld = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step(ld, d, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
